// File: rtl/button_led_arbiter.sv
// button_led_arbiter: shares an 8-LED bank between two debounced pushbuttons
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset
//   SW1   in   raw pushbutton 1 (async, 1 = pressed)
//   SW2   in   raw pushbutton 2 (async, 1 = pressed)
//   LEDS  out  [3:0] SW1 press count, [7:4] SW2 press count (owner nibble only)
//   owner out  00 none, 01 SW1, 10 SW2
//   busy  out  1 while a grant is active
module button_led_arbiter #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int HOLD_CYCLES     = 12000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SW1,
    input  logic       SW2,
    output logic [7:0] LEDS,
    output logic [1:0] owner,
    output logic       busy
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT1 = 2'b01,
        GRANT2 = 2'b10
    } state_t;

    logic [1:0]         meta_q, sync_q, deb_q, deb_d, prev_q, press;
    logic [1:0][DW-1:0] dcnt_q, dcnt_d;

    state_t             state_q, state_d;
    logic [1:0][3:0]    cnt_q, cnt_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               pend_q, pend_d;
    logic               last_q, last_d;
    logic [7:0]         leds_q, leds_d;
    logic [1:0]         owner_q, owner_d;
    logic               busy_q, busy_d;

    logic               own_idx, own_press, oth_press, pend_now, expire;

    // Debounce: the counter tracks consecutive cycles of disagreement; the
    // debounced level takes the synced level once that run is long enough.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i]  = (sync_q[i] != deb_q[i] && dcnt_q[i] == DEB_LAST) ? sync_q[i] : deb_q[i];
            dcnt_d[i] = (sync_q[i] == deb_q[i] || dcnt_q[i] == DEB_LAST) ? '0 : dcnt_q[i] + 1'b1;
        end
    end

    assign press = deb_q & ~prev_q;

    // Next-state logic; index 0 is SW1 and index 1 is SW2 throughout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q + 1'b1;
        pend_d    = pend_q;
        last_d    = last_q;
        own_idx   = (state_q == GRANT2);
        own_press = press[own_idx];
        oth_press = press[~own_idx];
        pend_now  = pend_q | oth_press;
        expire    = (timer_q == HOLD_LAST) && !own_press;
        if (state_q == IDLE) begin
            timer_d = '0;
            pend_d  = 1'b0;
            if (press != 2'b00) begin
                // On a tie, the button that did not win last time goes first.
                last_d        = (press == 2'b11) ? ~last_q : press[1];
                state_d       = last_d ? GRANT2 : GRANT1;
                cnt_d[last_d] = cnt_q[last_d] + 1'b1;
            end
        end else if (own_press) begin
            cnt_d[own_idx] = cnt_q[own_idx] + 1'b1;
            timer_d        = '0;
            pend_d         = pend_now;
        end else if (expire) begin
            timer_d = '0;
            pend_d  = 1'b0;
            state_d = IDLE;
            if (pend_now) begin
                last_d        = ~own_idx;
                state_d       = last_d ? GRANT2 : GRANT1;
                cnt_d[last_d] = cnt_q[last_d] + 1'b1;
            end
        end else begin
            pend_d = pend_now;
        end
    end

    // Outputs are registered from the next state so they change with it.
    always_comb begin
        leds_d  = (state_d == GRANT1) ? {4'h0, cnt_d[0]} :
                  (state_d == GRANT2) ? {cnt_d[1], 4'h0} : 8'h00;
        owner_d = state_d;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= '0;
            sync_q  <= '0;
            deb_q   <= '0;
            prev_q  <= '0;
            dcnt_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            timer_q <= '0;
            pend_q  <= 1'b0;
            last_q  <= 1'b1;
            leds_q  <= 8'h00;
            owner_q <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            meta_q  <= {SW2, SW1};
            sync_q  <= meta_q;
            deb_q   <= deb_d;
            prev_q  <= deb_q;
            dcnt_q  <= dcnt_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            leds_q  <= leds_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    assign LEDS  = leds_q;
    assign owner = owner_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_button_led_arbiter.sv
// tb_button_led_arbiter: directed scenarios plus randomized button traffic against a reference model
module tb_button_led_arbiter;
    localparam int DEB  = 4;
    localparam int HOLD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SW1 = 1'b0;
    logic       SW2 = 1'b0;
    logic [7:0] LEDS;
    logic [1:0] owner;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    button_led_arbiter #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .SW1(SW1), .SW2(SW2),
        .LEDS(LEDS), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: pin history window, grant owner, remaining hold cycles.
    bit   m_hist [2][DEB+2];
    bit   m_deb  [2];
    bit   m_press[2];
    int   m_cnt  [2];
    int   m_owner, m_left, m_last;
    bit   m_pend;
    logic [7:0] e_leds;
    logic [1:0] e_owner;
    logic       e_busy;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < DEB + 2; j++) m_hist[k][j] = 1'b0;
            m_deb[k] = 1'b0; m_press[k] = 1'b0; m_cnt[k] = 0;
        end
        m_owner = 0; m_left = 0; m_last = 2; m_pend = 1'b0;
    endtask

    task automatic grant(input int w);
        m_owner = w;
        m_cnt[w-1] = (m_cnt[w-1] + 1) % 16;
        m_left = HOLD;
        m_last = w;
    endtask

    task automatic model_step(input bit a, input bit b, input bit r);
        bit pin[2];
        bit diff;
        int o, x;
        pin[0] = a; pin[1] = b;
        if (r) begin
            model_reset();
        end else begin
            if (m_owner == 0) begin
                if (m_press[0] && m_press[1]) grant(3 - m_last);
                else if (m_press[0]) grant(1);
                else if (m_press[1]) grant(2);
            end else begin
                o = m_owner; x = 3 - o;
                if (m_press[x-1]) m_pend = 1'b1;
                if (m_press[o-1]) begin
                    m_cnt[o-1] = (m_cnt[o-1] + 1) % 16;
                    m_left = HOLD;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_pend) begin m_pend = 1'b0; grant(x); end
                        else m_owner = 0;
                    end
                end
            end
            // A level is accepted once the pin, seen two synchroniser stages late,
            // has disagreed with it for DEB samples in a row.
            for (int k = 0; k < 2; k++) begin
                for (int j = DEB + 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
                m_hist[k][0] = pin[k];
                diff = 1'b1;
                for (int j = 2; j <= DEB + 1; j++) if (m_hist[k][j] == m_deb[k]) diff = 1'b0;
                m_press[k] = diff && !m_deb[k];
                if (diff) m_deb[k] = !m_deb[k];
            end
        end
        e_owner = m_owner[1:0];
        e_busy  = (m_owner != 0);
        e_leds  = (m_owner == 1) ? 8'(m_cnt[0]) : (m_owner == 2) ? 8'(m_cnt[1] << 4) : 8'h00;
    endtask

    task automatic tick(input bit a, input bit b, input bit r);
        @(negedge clk);
        SW1 = a; SW2 = b; rst = r;
        @(posedge clk);
        model_step(a, b, r);
        #1;
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({LEDS, owner, busy} !== {8'h00, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: LEDS=%h owner=%b busy=%b, expected 00 00 0", LEDS, owner, busy);
        end
        for (int i = 1; i <= 4; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            n_tests++;
            if ({LEDS, owner, busy} !== {e_leds, e_owner, e_busy}) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: LEDS=%h owner=%b busy=%b, expected %h %b %b", i, LEDS, owner, busy, e_leds, e_owner, e_busy);
            end
        end
    endtask

    task automatic test_bounce();
        bit a;
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            a = (i > 20) ? 1'b1 : 1'(((i + 1) / 2) % 2);
            tick(a, 1'b0, 1'b0);
            n_tests++;
            if ({LEDS, owner, busy} !== {e_leds, e_owner, e_busy}) begin
                n_fail++;
                $display("FAIL bounce cyc %0d: LEDS=%h owner=%b busy=%b, expected %h %b %b", i, LEDS, owner, busy, e_leds, e_owner, e_busy);
            end
            if (i == 26) begin
                n_tests++;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL bounce_no_early_grant: busy=%b, expected 0", busy); end
            end
            if (i == 27 || i == 30) begin
                n_tests++;
                if ({LEDS, owner, busy} !== {8'h01, 2'b01, 1'b1}) begin
                    n_fail++;
                    $display("FAIL bounce_one_grant cyc %0d: LEDS=%h owner=%b busy=%b, expected 01 01 1", i, LEDS, owner, busy);
                end
            end
        end
    endtask

    task automatic test_expiry();
        for (int j = 1; j <= 16; j++) begin
            tick(1'b1, 1'b0, 1'b0);
            n_tests++;
            if ({LEDS, owner, busy} !== {e_leds, e_owner, e_busy}) begin
                n_fail++;
                $display("FAIL expiry cyc %0d: LEDS=%h owner=%b busy=%b, expected %h %b %b", j, LEDS, owner, busy, e_leds, e_owner, e_busy);
            end
            if (j == 12) begin
                n_tests++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL expiry_last_cycle: busy=%b, expected 1", busy); end
            end
            if (j == 13) begin
                n_tests++;
                if ({LEDS, owner, busy} !== {8'h00, 2'b00, 1'b0}) begin
                    n_fail++;
                    $display("FAIL expiry_idle: LEDS=%h owner=%b busy=%b, expected 00 00 0", LEDS, owner, busy);
                end
            end
        end
    endtask

    task automatic test_restart();
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            tick((i <= 4) || (i >= 11), 1'b0, 1'b0);
            n_tests++;
            if ({LEDS, owner, busy} !== {e_leds, e_owner, e_busy}) begin
                n_fail++;
                $display("FAIL restart cyc %0d: LEDS=%h owner=%b busy=%b, expected %h %b %b", i, LEDS, owner, busy, e_leds, e_owner, e_busy);
            end
            if (i == 16 || i == 17) begin
                n_tests++;
                if (LEDS !== ((i == 16) ? 8'h01 : 8'h02)) begin
                    n_fail++;
                    $display("FAIL restart_count cyc %0d: LEDS=%h, expected %h", i, LEDS, (i == 16) ? 8'h01 : 8'h02);
                end
            end
            if (i == 32 || i == 33) begin
                n_tests++;
                if (busy !== (i == 32)) begin
                    n_fail++;
                    $display("FAIL restart_window cyc %0d: busy=%b, expected %b", i, busy, i == 32);
                end
            end
        end
    endtask

    task automatic test_pending();
        do_reset();
        for (int i = 1; i <= 42; i++) begin
            tick(1'b1, (i >= 3 && i <= 6) || (i >= 11), 1'b0);
            n_tests++;
            if ({LEDS, owner, busy} !== {e_leds, e_owner, e_busy}) begin
                n_fail++;
                $display("FAIL pending cyc %0d: LEDS=%h owner=%b busy=%b, expected %h %b %b", i, LEDS, owner, busy, e_leds, e_owner, e_busy);
            end
            if (i == 22) begin
                n_tests++;
                if ({LEDS, owner} !== {8'h01, 2'b01}) begin n_fail++; $display("FAIL pending_before: LEDS=%h owner=%b, expected 01 01", LEDS, owner); end
            end
            if (i == 23) begin
                n_tests++;
                if ({LEDS, owner, busy} !== {8'h10, 2'b10, 1'b1}) begin n_fail++; $display("FAIL pending_transfer: LEDS=%h owner=%b busy=%b, expected 10 10 1", LEDS, owner, busy); end
            end
            if (i == 39) begin
                n_tests++;
                if ({LEDS, owner, busy} !== {8'h00, 2'b00, 1'b0}) begin n_fail++; $display("FAIL pending_idle: LEDS=%h owner=%b busy=%b, expected 00 00 0", LEDS, owner, busy); end
            end
        end
    endtask

    task automatic test_tie();
        bit p;
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            p = (i <= 23) || (i >= 30);
            tick(p, p, 1'b0);
            n_tests++;
            if ({LEDS, owner, busy} !== {e_leds, e_owner, e_busy}) begin
                n_fail++;
                $display("FAIL tie cyc %0d: LEDS=%h owner=%b busy=%b, expected %h %b %b", i, LEDS, owner, busy, e_leds, e_owner, e_busy);
            end
            if (i == 7) begin
                n_tests++;
                if ({LEDS, owner} !== {8'h01, 2'b01}) begin n_fail++; $display("FAIL tie_first: LEDS=%h owner=%b, expected 01 01", LEDS, owner); end
            end
            if (i == 36) begin
                n_tests++;
                if ({LEDS, owner, busy} !== {8'h10, 2'b10, 1'b1}) begin n_fail++; $display("FAIL tie_second: LEDS=%h owner=%b busy=%b, expected 10 10 1", LEDS, owner, busy); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 1'b0, i == 10);
            n_tests++;
            if ({LEDS, owner, busy} !== {e_leds, e_owner, e_busy}) begin
                n_fail++;
                $display("FAIL reset_mid cyc %0d: LEDS=%h owner=%b busy=%b, expected %h %b %b", i, LEDS, owner, busy, e_leds, e_owner, e_busy);
            end
            if (i == 10 || i == 16) begin
                n_tests++;
                if ({LEDS, owner, busy} !== {8'h00, 2'b00, 1'b0}) begin n_fail++; $display("FAIL reset_mid_clear cyc %0d: LEDS=%h owner=%b busy=%b, expected 00 00 0", i, LEDS, owner, busy); end
            end
            if (i == 17) begin
                n_tests++;
                if ({LEDS, owner, busy} !== {8'h01, 2'b01, 1'b1}) begin n_fail++; $display("FAIL reset_mid_regrant: LEDS=%h owner=%b busy=%b, expected 01 01 1", LEDS, owner, busy); end
            end
        end
    endtask

    task automatic test_random();
        bit a = 1'b0, b = 1'b0, r;
        int ra = 0, rb = 0;
        do_reset();
        for (int i = 1; i <= 4000; i++) begin
            if (ra == 0) begin a = 1'($urandom_range(0, 1)); ra = $urandom_range(1, 12); end
            if (rb == 0) begin b = 1'($urandom_range(0, 1)); rb = $urandom_range(1, 12); end
            ra--; rb--;
            r = ($urandom_range(0, 399) == 0);
            tick(a, b, r);
            n_tests++;
            if ({LEDS, owner, busy} !== {e_leds, e_owner, e_busy}) begin
                n_fail++;
                $display("FAIL random cyc %0d: LEDS=%h owner=%b busy=%b, expected %h %b %b", i, LEDS, owner, busy, e_leds, e_owner, e_busy);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bounce();
        test_expiry();
        test_restart();
        test_pending();
        test_tie();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
